// File: rtl/timer_pwm.sv
// timer_pwm: 16-bit prescaled timer with period/compare registers,
// sticky overflow/compare flags, PWM output and a level interrupt.
// Registers are reached through a simple strobe bus with one-cycle read latency.
module timer_pwm #(
  parameter logic [10:0] TCR_ADDR  = 11'h407,
  parameter logic [10:0] TCNT_ADDR = 11'h408,
  parameter logic [10:0] TTOP_ADDR = 11'h409,
  parameter logic [10:0] TCMP_ADDR = 11'h40A,
  parameter logic [10:0] TSR_ADDR  = 11'h40B
) (
  input  logic        clk,
  input  logic        rstB,
  input  logic [10:0] addr,
  input  logic [31:0] wrData,
  input  logic        wrEn,
  input  logic        rdEn,
  output logic [31:0] dataOut,
  output logic        outEn,
  output logic        pwmOut,
  output logic        irq
);

  // TCR bit positions
  localparam int EN_BIT    = 0;
  localparam int ONESHOT_B = 1;
  localparam int PWMEN_BIT = 2;
  localparam int POL_BIT   = 3;
  localparam int OVFIE_BIT = 8;
  localparam int CMPIE_BIT = 9;

  logic [9:0]  tcr_q, tcr_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [15:0] ttop_q, ttop_d;
  logic [15:0] tcmp_q, tcmp_d;
  logic [1:0]  tsr_q, tsr_d;
  logic [9:0]  presc_q, presc_d;
  logic        pwm_q, pwm_d;
  logic        irq_q, irq_d;
  logic        outEn_q, outEn_d;
  logic [31:0] dataOut_q, dataOut_d;

  logic selTcr, selTcnt, selTtop, selTcmp, selTsr;
  logic wrTcr, wrTcnt, wrTtop, wrTcmp, wrTsr;
  logic [3:0]  psEff;
  logic [10:0] psOne;
  logic [9:0]  psMask;
  logic        tick;
  logic        ovfSet, cmpSet;

  assign selTcr  = (addr == TCR_ADDR);
  assign selTcnt = (addr == TCNT_ADDR);
  assign selTtop = (addr == TTOP_ADDR);
  assign selTcmp = (addr == TCMP_ADDR);
  assign selTsr  = (addr == TSR_ADDR);

  assign wrTcr  = wrEn & selTcr;
  assign wrTcnt = wrEn & selTcnt;
  assign wrTtop = wrEn & selTtop;
  assign wrTcmp = wrEn & selTcmp;
  assign wrTsr  = wrEn & selTsr;

  // Prescaler divide is clamped at 2^10; a mask of all-low-bits-set marks the tick.
  // For PS=10 the shifted one falls off the 10-bit slice and the subtraction wraps to 10'h3FF.
  assign psEff  = (tcr_q[7:4] > 4'd10) ? 4'd10 : tcr_q[7:4];
  assign psOne  = 11'd1 << psEff;
  assign psMask = psOne[9:0] - 10'd1;
  assign tick   = tcr_q[EN_BIT] & ((presc_q & psMask) == psMask);

  // Next-state logic for control, counter, flags and prescaler
  always_comb begin
    tcr_d   = tcr_q;
    tcnt_d  = tcnt_q;
    ttop_d  = ttop_q;
    tcmp_d  = tcmp_q;
    ovfSet  = 1'b0;
    cmpSet  = 1'b0;
    presc_d = presc_q + 10'd1;

    if (wrTcr)  tcr_d  = wrData[9:0];
    if (wrTtop) ttop_d = wrData[15:0];
    if (wrTcmp) tcmp_d = wrData[15:0];

    // A software load of TCNT swallows any tick landing on the same edge.
    if (wrTcnt) begin
      tcnt_d = wrData[15:0];
    end else if (tick) begin
      if (tcnt_q == ttop_q) begin
        tcnt_d = 16'd0;
        ovfSet = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 16'd1;
      end
      if (tcnt_q == tcmp_q) cmpSet = 1'b1;
    end

    // One-shot mode stops the timer on the very edge that overflows it.
    if (ovfSet && tcr_q[ONESHOT_B]) tcr_d[EN_BIT] = 1'b0;

    // Stopped timer holds the prescaler at zero, so an EN 0->1 write always
    // starts from a clean phase; a TCNT load realigns the phase as well.
    if (!tcr_q[EN_BIT] || wrTcnt) presc_d = 10'd0;

    // Write-1-to-clear, with a same-edge hardware event taking priority.
    tsr_d = (tsr_q & ~(wrTsr ? wrData[1:0] : 2'b00)) | {cmpSet, ovfSet};
  end

  // Output stage: PWM level, interrupt and read response, each one cycle late
  always_comb begin
    pwm_d = tcr_q[PWMEN_BIT] ? ((tcnt_q < tcmp_q) ^ tcr_q[POL_BIT]) : tcr_q[POL_BIT];
    irq_d = (tsr_q[0] & tcr_q[OVFIE_BIT]) | (tsr_q[1] & tcr_q[CMPIE_BIT]);

    outEn_d   = 1'b0;
    dataOut_d = 32'd0;
    if (rdEn) begin
      if (selTcr) begin
        outEn_d   = 1'b1;
        dataOut_d = {22'd0, tcr_q};
      end else if (selTcnt) begin
        outEn_d   = 1'b1;
        dataOut_d = {16'd0, tcnt_q};
      end else if (selTtop) begin
        outEn_d   = 1'b1;
        dataOut_d = {16'd0, ttop_q};
      end else if (selTcmp) begin
        outEn_d   = 1'b1;
        dataOut_d = {16'd0, tcmp_q};
      end else if (selTsr) begin
        outEn_d   = 1'b1;
        dataOut_d = {30'd0, tsr_q};
      end
    end
  end

  // State registers with synchronous active-low reset overriding everything
  always_ff @(posedge clk) begin
    if (!rstB) begin
      tcr_q     <= 10'd0;
      tcnt_q    <= 16'd0;
      ttop_q    <= 16'hFFFF;
      tcmp_q    <= 16'd0;
      tsr_q     <= 2'b00;
      presc_q   <= 10'd0;
      pwm_q     <= 1'b0;
      irq_q     <= 1'b0;
      outEn_q   <= 1'b0;
      dataOut_q <= 32'd0;
    end else begin
      tcr_q     <= tcr_d;
      tcnt_q    <= tcnt_d;
      ttop_q    <= ttop_d;
      tcmp_q    <= tcmp_d;
      tsr_q     <= tsr_d;
      presc_q   <= presc_d;
      pwm_q     <= pwm_d;
      irq_q     <= irq_d;
      outEn_q   <= outEn_d;
      dataOut_q <= dataOut_d;
    end
  end

  assign pwmOut  = pwm_q;
  assign irq     = irq_q;
  assign outEn   = outEn_q;
  assign dataOut = dataOut_q;

endmodule
